// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the next_pc_unit program-counter sequencer.
package mips_pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5
  } br_type_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } npc_state_t;

  // Raw branch condition codes as they arrive on br_type_i
  localparam logic [2:0] BRC_NONE = 3'd0;
  localparam logic [2:0] BRC_BEQ  = 3'd1;
  localparam logic [2:0] BRC_BNE  = 3'd2;
  localparam logic [2:0] BRC_BLEZ = 3'd3;
  localparam logic [2:0] BRC_BGTZ = 3'd4;
  localparam logic [2:0] BRC_BLTZ = 3'd5;

  // Branch resolution from ALU flags; unknown codes (6, 7) are never taken.
  function automatic logic br_taken(input logic [2:0] br_type,
                                    input logic       zero,
                                    input logic       lt,
                                    input logic       gt);
    logic t;
    t = 1'b0;
    case (br_type)
      BRC_BEQ:  t = zero;
      BRC_BNE:  t = ~zero;
      BRC_BLEZ: t = lt | zero;
      BRC_BGTZ: t = gt;
      BRC_BLTZ: t = lt;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Circular return-address stack. Overflow overwrites the oldest entry,
// an empty pop is ignored. Contents are not reset; occupancy is.
module ras_stack
  import mips_pc_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [AW-1:0]            data_i,
  output logic [AW-1:0]            top_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wr_idx;
  logic          wr_en;
  logic          pop_ok;

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_idx = ptr_q - PW'(1);
  assign pop_ok  = pop_i & ~empty_o;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  // Pointer/occupancy update; push+pop together replaces the top entry
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_ok) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop_ok) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the stack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written on push
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter sequencer for the single-cycle MIPS core.
// Optional return-address stack enabled by defining NPC_RAS_EN.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_BOOT  | one cycle after reset, PC held at RESET_PC, not valid
//   ST_RUN   | normal fetch; PC advances by stall/jr/jump/branch/seq priority
//   ST_FAULT | misaligned jr target seen; PC frozen until reset
//
// BOOT holds RESET_PC, so the reset vector itself is the first valid fetch.
module next_pc_unit
  import mips_pc_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic [2:0]    br_type_i,
  input  logic          zero_i,
  input  logic          lt_i,
  input  logic          gt_i,
  input  logic [15:0]   offset_i,
  input  logic          jump_i,
  input  logic          jal_i,
  input  logic [25:0]   jidx_i,
  input  logic          jr_i,
  input  logic          jr_ra_i,
  input  logic [AW-1:0] jr_target_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] link_o,
  output logic          pc_valid_o,
  output logic          redirect_o,
  output logic          fault_o,
  output logic [AW-1:0] ras_top_o,
  output logic          ras_mismatch_o
);

  localparam logic [AW-1:0] JMASK = AW'({28{1'b1}});

  npc_state_t    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] jmp_tgt;
  logic          run_go;
  logic          taken;
  logic          jr_misaligned;

  assign run_go        = (state_q == ST_RUN) & ~stall_i;
  assign taken         = br_taken(br_type_i, zero_i, lt_i, gt_i);
  assign jr_misaligned = |jr_target_i[1:0];

  assign link_o  = pc_q + AW'(4);
  assign off_ext = {{(AW-16){offset_i[15]}}, offset_i};
  assign br_tgt  = link_o + (off_ext << 2);
  assign jmp_tgt = (link_o & ~JMASK) | AW'({jidx_i, 2'b00});
  assign pc_o    = pc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic; stall is ignored in BOOT, everything is ignored in FAULT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (run_go && jr_i && jr_misaligned) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    pc_valid_o = (state_q == ST_RUN);
    fault_o    = (state_q == ST_FAULT);
    redirect_o = run_go & (jr_i | jump_i | jal_i | taken);
  end

  // Next-PC selection: stall > jr > jump/jal > taken branch > sequential
  always_comb begin
    pc_d = pc_q;
    if (run_go) begin
      if (jr_i) begin
        if (!jr_misaligned) pc_d = jr_target_i;
      end else if (jump_i || jal_i) begin
        pc_d = jmp_tgt;
      end else if (taken) begin
        pc_d = br_tgt;
      end else begin
        pc_d = link_o;
      end
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

`ifdef NPC_RAS_EN
  logic                         ras_push;
  logic                         ras_pop;
  logic                         ras_empty;
  logic [AW-1:0]                ras_top;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         unused_ras;

  // A jal that loses to a simultaneous jr was never executed, so it does not push
  assign ras_push = run_go & jal_i & ~jr_i;
  assign ras_pop  = run_go & jr_i & jr_ra_i;

  ras_stack #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (link_o),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .count_o (ras_count)
  );

  // Prediction is advisory only; the jr target always comes from the register file
  assign ras_top_o      = ras_top;
  assign ras_mismatch_o = ras_pop & (ras_empty | (ras_top != jr_target_i));
  assign unused_ras     = ^ras_count;
`else
  logic unused_ras;

  assign ras_top_o      = '0;
  assign ras_mismatch_o = 1'b0;
  assign unused_ras     = jr_ra_i;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit (AW=32, RESET_PC=0x400, RAS_DEPTH=4).
module tb_next_pc_unit;
  import mips_pc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h400;
`ifdef NPC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk, rst_n, stall_i;
  logic [2:0]  br_type_i;
  logic        zero_i, lt_i, gt_i;
  logic [15:0] offset_i;
  logic        jump_i, jal_i;
  logic [25:0] jidx_i;
  logic        jr_i, jr_ra_i;
  logic [31:0] jr_target_i;
  logic [31:0] pc_o, link_o, ras_top_o;
  logic        pc_valid_o, redirect_o, fault_o, ras_mismatch_o;

  int n_cmp = 0;
  int n_bad = 0;

  next_pc_unit #(.AW(32), .RESET_PC(RST_PC), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .br_type_i(br_type_i),
    .zero_i(zero_i), .lt_i(lt_i), .gt_i(gt_i), .offset_i(offset_i),
    .jump_i(jump_i), .jal_i(jal_i), .jidx_i(jidx_i), .jr_i(jr_i),
    .jr_ra_i(jr_ra_i), .jr_target_i(jr_target_i), .pc_o(pc_o),
    .link_o(link_o), .pc_valid_o(pc_valid_o), .redirect_o(redirect_o),
    .fault_o(fault_o), .ras_top_o(ras_top_o), .ras_mismatch_o(ras_mismatch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  br;
    logic        zero, lt, gt;
    logic [15:0] off;
    logic        jump, jal;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jtgt;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_red;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic stall, input logic [2:0] br,
                              input logic zero, input logic lt, input logic gt,
                              input logic [15:0] off, input logic jump, input logic jal,
                              input logic [25:0] jidx, input logic jr, input logic [31:0] jtgt,
                              input logic [31:0] exp_pc, input logic exp_valid,
                              input logic exp_red);
    vec_t v;
    v.stall = stall; v.br = br; v.zero = zero; v.lt = lt; v.gt = gt;
    v.off = off; v.jump = jump; v.jal = jal; v.jidx = jidx; v.jr = jr;
    v.jtgt = jtgt; v.exp_pc = exp_pc; v.exp_valid = exp_valid; v.exp_red = exp_red;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    stall_i = 0; br_type_i = 3'd0; zero_i = 0; lt_i = 0; gt_i = 0;
    offset_i = 16'h0; jump_i = 0; jal_i = 0; jidx_i = 26'h0;
    jr_i = 0; jr_ra_i = 0; jr_target_i = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    stall_i = v.stall; br_type_i = v.br; zero_i = v.zero; lt_i = v.lt; gt_i = v.gt;
    offset_i = v.off; jump_i = v.jump; jal_i = v.jal; jidx_i = v.jidx;
    jr_i = v.jr; jr_ra_i = 1'b0; jr_target_i = v.jtgt;
  endtask

  logic [31:0] model_top;
  logic [31:0] exp_top;
  logic [31:0] prev_tgt;

  initial begin
    //               stall br zero lt gt off       jump jal jidx     jr  jtgt          exp_pc        v  red
    tbl[0]  = mk(1, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0400, 0, 0);
    tbl[1]  = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0400, 1, 0);
    tbl[2]  = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0404, 1, 0);
    tbl[3]  = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   1, 32'h100,       32'h0000_0408, 1, 1);
    tbl[4]  = mk(0, 3'd1, 1, 0, 0, 16'hFFFE, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0100, 1, 1);
    tbl[5]  = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   1, 32'h100,       32'h0000_00FC, 1, 1);
    tbl[6]  = mk(0, 3'd1, 0, 0, 0, 16'hFFFE, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0100, 1, 0);
    tbl[7]  = mk(1, 3'd1, 1, 0, 0, 16'hFFFE, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0104, 1, 0);
    tbl[8]  = mk(0, 3'd2, 0, 0, 0, 16'h0003, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0104, 1, 1);
    tbl[9]  = mk(0, 3'd3, 0, 0, 0, 16'h0010, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0114, 1, 0);
    tbl[10] = mk(0, 3'd3, 1, 0, 0, 16'h0001, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0118, 1, 1);
    tbl[11] = mk(0, 3'd4, 0, 0, 1, 16'h0000, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0120, 1, 1);
    tbl[12] = mk(0, 3'd4, 0, 1, 0, 16'h0005, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0124, 1, 0);
    tbl[13] = mk(0, 3'd5, 0, 1, 0, 16'hFFFF, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0128, 1, 1);
    tbl[14] = mk(0, 3'd6, 1, 1, 1, 16'h0005, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0128, 1, 0);
    tbl[15] = mk(0, 3'd7, 1, 1, 1, 16'h0005, 0, 0, 26'h0,   0, 32'h0,         32'h0000_012C, 1, 0);
    tbl[16] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 1, 0, 26'h40,  0, 32'h0,         32'h0000_0130, 1, 1);
    tbl[17] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   1, 32'h3000_0000, 32'h0000_0100, 1, 1);
    tbl[18] = mk(1, 3'd0, 0, 0, 0, 16'h0000, 0, 1, 26'h40,  0, 32'h0,         32'h3000_0000, 1, 0);
    tbl[19] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 1, 26'h40,  0, 32'h0,         32'h3000_0000, 1, 1);
    tbl[20] = mk(0, 3'd1, 1, 0, 0, 16'h0005, 1, 0, 26'h15,  1, 32'hFFFF_FFFC, 32'h3000_0100, 1, 1);
    tbl[21] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   0, 32'h0,         32'hFFFF_FFFC, 1, 0);
    tbl[22] = mk(0, 3'd1, 1, 0, 0, 16'h0005, 1, 0, 26'h10,  0, 32'h0,         32'h0000_0000, 1, 1);
    tbl[23] = mk(0, 3'd5, 0, 0, 1, 16'h0005, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0040, 1, 0);
    tbl[24] = mk(0, 3'd2, 1, 0, 0, 16'h0007, 0, 0, 26'h0,   0, 32'h0,         32'h0000_0044, 1, 0);
    tbl[25] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   1, 32'hF000_0010, 32'h0000_0048, 1, 1);
    tbl[26] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 1, 0, 26'h3,   0, 32'h0,         32'hF000_0010, 1, 1);
    tbl[27] = mk(0, 3'd0, 0, 0, 0, 16'h0000, 0, 0, 26'h0,   0, 32'h0,         32'hF000_000C, 1, 0);

    // Reset: jump asserted to show redirect stays low outside RUN
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    jump_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_valid", 32'(pc_valid_o), 32'd0);
    chk("rst_redirect", 32'(redirect_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_ras_top", ras_top_o, 32'd0);
    chk("rst_ras_mis", 32'(ras_mismatch_o), 32'd0);
    idle();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Table: each record is checked against the current PC, then clocked
    model_top = 32'h0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_pc", i), pc_o, tbl[i].exp_pc);
      chk($sformatf("v%0d_link", i), link_o, tbl[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_valid", i), 32'(pc_valid_o), 32'(tbl[i].exp_valid));
      chk($sformatf("v%0d_redirect", i), 32'(redirect_o), 32'(tbl[i].exp_red));
      chk($sformatf("v%0d_fault", i), 32'(fault_o), 32'd0);
      chk($sformatf("v%0d_ras_top", i), ras_top_o, model_top);
      chk($sformatf("v%0d_ras_mis", i), 32'(ras_mismatch_o), 32'd0);
      if (RAS_ON && i > 0 && !tbl[i].stall && tbl[i].jal && !tbl[i].jr)
        model_top = tbl[i].exp_pc + 32'd4;
    end

    // Misaligned jr: fault, PC frozen, inputs ignored
    @(negedge clk);
    idle();
    jr_i = 1'b1;
    jr_target_i = 32'h202;
    #1;
    chk("flt_pc_before", pc_o, 32'hF000_0010);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle();
      jump_i = 1'($urandom_range(0, 1));
      jr_i = 1'b1;
      jr_ra_i = 1'b1;
      jr_target_i = 32'h100;
      stall_i = 1'(k % 2);
      #1;
      chk($sformatf("flt%0d_pc", k), pc_o, 32'hF000_0010);
      chk($sformatf("flt%0d_fault", k), 32'(fault_o), 32'd1);
      chk($sformatf("flt%0d_valid", k), 32'(pc_valid_o), 32'd0);
      chk($sformatf("flt%0d_redirect", k), 32'(redirect_o), 32'd0);
      chk($sformatf("flt%0d_ras_mis", k), 32'(ras_mismatch_o), 32'd0);
    end

    // Mid-cycle asynchronous reset
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_o, RST_PC);
    chk("arst_fault", 32'(fault_o), 32'd0);
    chk("arst_valid", 32'(pc_valid_o), 32'd0);
    chk("arst_ras_top", ras_top_o, 32'd0);
    idle();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // BOOT then RUN at the reset vector, jump to 0x10
    @(negedge clk);
    #1;
    chk("boot2_valid", 32'(pc_valid_o), 32'd0);
    @(negedge clk);
    jr_i = 1'b1;
    jr_target_i = 32'h10;
    #1;
    chk("run2_pc", pc_o, RST_PC);
    chk("run2_valid", 32'(pc_valid_o), 32'd1);

    // Five jal pushes from 0x10..0x50; the earlier push was cleared by reset
    exp_top = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idle();
      jal_i = 1'b1;
      jidx_i = 26'((k + 1) * 4);
      #1;
      chk($sformatf("jal%0d_pc", k), pc_o, 32'(k * 16));
      chk($sformatf("jal%0d_ras_top", k), ras_top_o, exp_top);
      chk($sformatf("jal%0d_redirect", k), 32'(redirect_o), 32'd1);
      if (RAS_ON) exp_top = 32'(k * 16 + 4);
    end

    // Five jr $ra pops; 0x14 was overwritten, so the last pop mispredicts
    prev_tgt = 32'h60;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      idle();
      jr_i = 1'b1;
      jr_ra_i = 1'b1;
      jr_target_i = 32'h54 - 32'(16 * j);
      #1;
      chk($sformatf("pop%0d_pc", j), pc_o, prev_tgt);
      chk($sformatf("pop%0d_ras_top", j), ras_top_o,
          (RAS_ON && j < 4) ? jr_target_i : 32'h0);
      chk($sformatf("pop%0d_ras_mis", j), 32'(ras_mismatch_o),
          32'(RAS_ON && j == 4));
      chk($sformatf("pop%0d_redirect", j), 32'(redirect_o), 32'd1);
      prev_tgt = jr_target_i;
    end
    @(negedge clk);
    idle();
    #1;
    chk("pop_final_pc", pc_o, 32'h14);
    chk("pop_final_ras_top", ras_top_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
